clock_divider_prog: RTL and testbench

//   Runtime-programmable clock divider: divides clk_in by a loadable ratio with
//   a loadable high time (duty cycle). Produces a registered clk_out and a
//   one-cycle tick strobe at each period start. New ratios are taken through a

---
 rtl/clock_divider_prog.sv | 161 ++++++++++++++++
 tb/tb_clock_divider_prog.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_divider_prog.sv
// Runtime-programmable clock divider.
// Divides clk_in by a loadable period (div) with a loadable high time (high).
// New settings arrive through a valid/ready handshake. They are applied only
// at a period boundary (or while idle), so clk_out never glitches.
//
// Ports:
//   clk_in    - system clock, rising edge
//   reset_n   - asynchronous active-low reset
//   enable    - 1 = run, 0 = stop and hold clk_out low
//   div_val   - requested period in clk_in cycles (values below 2 are stored as 2)
//   high_val  - requested high time in clk_in cycles
//   cfg_valid - div_val/high_val are valid this cycle
//   cfg_ready - a config can be accepted (no config pending), registered
//   clk_out   - divided clock, registered
//   tick      - one-cycle pulse on the first cycle of each period, registered
//   active    - 1 while running, registered
module clock_divider_prog #(
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned DEF_DIV  = 1024,
    parameter int unsigned DEF_HIGH = 512
) (
    input  logic             clk_in,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [CNT_W-1:0] div_val,
    input  logic [CNT_W-1:0] high_val,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    output logic             clk_out,
    output logic             tick,
    output logic             active
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] MIN_DIV = CNT_W'(2);

    state_t           state_q,     state_d;
    logic [CNT_W-1:0] cnt_q,       cnt_d;
    logic [CNT_W-1:0] div_q,       div_d;
    logic [CNT_W-1:0] high_q,      high_d;
    logic [CNT_W-1:0] pend_div_q,  pend_div_d;
    logic [CNT_W-1:0] pend_high_q, pend_high_d;
    logic             pending_q,   pending_d;
    logic             clk_out_q,   clk_out_d;
    logic             tick_q,      tick_d;
    logic             cfg_ready_q, cfg_ready_d;
    logic             active_q,    active_d;

    logic             accept;
    logic             wrap;
    logic             apply;
    logic [CNT_W-1:0] new_high;
    logic [CNT_W-1:0] cnt_inc;

    // Next-state, counter, config and output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        div_d       = div_q;
        high_d      = high_q;
        pend_div_d  = pend_div_q;
        pend_high_d = pend_high_q;
        pending_d   = pending_q;
        clk_out_d   = 1'b0;
        tick_d      = 1'b0;
        apply       = 1'b0;

        accept   = cfg_valid & cfg_ready_q;
        wrap     = (cnt_q == (div_q - CNT_W'(1)));
        cnt_inc  = cnt_q + CNT_W'(1);
        // High time in force for a period that starts on this edge.
        new_high = pending_q ? pend_high_q : high_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                apply = pending_q;
                if (enable) begin
                    state_d   = ST_RUN;
                    tick_d    = 1'b1;
                    clk_out_d = (new_high != '0);
                end
            end
            ST_RUN: begin
                if (!enable) begin
                    // Truncate the current period and park low.
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (wrap) begin
                    apply     = pending_q;
                    cnt_d     = '0;
                    tick_d    = 1'b1;
                    clk_out_d = (new_high != '0);
                end else begin
                    cnt_d     = cnt_inc;
                    clk_out_d = (cnt_inc < high_q);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (apply) begin
            div_d     = pend_div_q;
            high_d    = pend_high_q;
            pending_d = 1'b0;
        end

        // Accept needs pending_q == 0, so it never collides with apply; a config
        // taken on a wrap cycle therefore waits for the following wrap.
        if (accept) begin
            pend_div_d  = (div_val < MIN_DIV) ? MIN_DIV : div_val;
            pend_high_d = high_val;
            pending_d   = 1'b1;
        end

        cfg_ready_d = !pending_d;
        active_d    = (state_d == ST_RUN);
    end

    // State and output registers.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            div_q       <= CNT_W'(DEF_DIV);
            high_q      <= CNT_W'(DEF_HIGH);
            pend_div_q  <= '0;
            pend_high_q <= '0;
            pending_q   <= 1'b0;
            clk_out_q   <= 1'b0;
            tick_q      <= 1'b0;
            cfg_ready_q <= 1'b1;
            active_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            div_q       <= div_d;
            high_q      <= high_d;
            pend_div_q  <= pend_div_d;
            pend_high_q <= pend_high_d;
            pending_q   <= pending_d;
            clk_out_q   <= clk_out_d;
            tick_q      <= tick_d;
            cfg_ready_q <= cfg_ready_d;
            active_q    <= active_d;
        end
    end

    assign cfg_ready = cfg_ready_q;
    assign clk_out   = clk_out_q;
    assign tick      = tick_q;
    assign active    = active_q;

endmodule

// File: tb/tb_clock_divider_prog.sv
// Directed testbench for clock_divider_prog.
// One task per scenario. Expected values are hand-computed, and every task
// compares the DUT outputs against them inline.
module tb_clock_divider_prog;

    localparam int unsigned CNT_W = 16;

    logic             clk_in;
    logic             reset_n;
    logic             enable;
    logic [CNT_W-1:0] div_val;
    logic [CNT_W-1:0] high_val;
    logic             cfg_valid;
    logic             cfg_ready;
    logic             clk_out;
    logic             tick;
    logic             active;

    int checks;
    int errors;

    clock_divider_prog #(
        .CNT_W   (CNT_W),
        .DEF_DIV (1024),
        .DEF_HIGH(512)
    ) dut (
        .clk_in   (clk_in),
        .reset_n  (reset_n),
        .enable   (enable),
        .div_val  (div_val),
        .high_val (high_val),
        .cfg_valid(cfg_valid),
        .cfg_ready(cfg_ready),
        .clk_out  (clk_out),
        .tick     (tick),
        .active   (active)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // Advance one clk_in cycle and settle just after the rising edge.
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // Stop, load a config while idle, let it apply, then enable.
    // The sample taken after the next step() is the first cycle of a period.
    task automatic load_idle_and_start(input logic [CNT_W-1:0] d, input logic [CNT_W-1:0] h);
        enable = 1'b0;
        step();
        div_val   = d;
        high_val  = h;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        step();
        enable = 1'b1;
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        enable    = 1'b0;
        cfg_valid = 1'b0;
        div_val   = '0;
        high_val  = '0;
        repeat (3) step();
        checks++;
        if ({clk_out, tick, cfg_ready, active} !== 4'b0010) begin
            errors++;
            $display("FAIL reset_state: got clk_out/tick/cfg_ready/active=%b, want 0010",
                     {clk_out, tick, cfg_ready, active});
        end
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if ({clk_out, tick, cfg_ready, active} !== 4'b0010) begin
                errors++;
                $display("FAIL idle_after_reset cyc%0d: got %b, want 0010", i,
                         {clk_out, tick, cfg_ready, active});
            end
        end
    endtask

    task automatic test_basic_div4();
        enable    = 1'b0;
        div_val   = 16'd4;
        high_val  = 16'd2;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        checks++;
        if (cfg_ready !== 1'b0) begin
            errors++;
            $display("FAIL cfg_ready_pending_idle: got %b, want 0", cfg_ready);
        end
        step();
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++;
            $display("FAIL cfg_ready_after_idle_apply: got %b, want 1", cfg_ready);
        end
        enable = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            checks++;
            if ({clk_out, tick, active} !== {((i % 4) < 2), ((i % 4) == 0), 1'b1}) begin
                errors++;
                $display("FAIL div4_high2 cyc%0d: got clk/tick/active=%b, want %b", i,
                         {clk_out, tick, active}, {((i % 4) < 2), ((i % 4) == 0), 1'b1});
            end
        end
    endtask

    // Entered with the div=4/high=2 run on its last cycle (cnt=3).
    task automatic test_reload_mid_period();
        step();
        checks++;
        if ({clk_out, tick} !== 2'b11) begin
            errors++;
            $display("FAIL reload_period_start: got clk/tick=%b, want 11", {clk_out, tick});
        end
        div_val   = 16'd5;
        high_val  = 16'd1;
        cfg_valid = 1'b1;
        // The old 4-cycle period runs to completion: cnt 1..3 give 1,0,0.
        for (int i = 1; i < 4; i++) begin
            step();
            cfg_valid = 1'b0;
            checks++;
            if ({clk_out, tick, cfg_ready} !== {(i < 2), 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL reload_old_period cnt%0d: got clk/tick/cfg_ready=%b, want %b", i,
                         {clk_out, tick, cfg_ready}, {(i < 2), 1'b0, 1'b0});
            end
        end
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if ({clk_out, tick, cfg_ready} !== {((i % 5) == 0), ((i % 5) == 0), 1'b1}) begin
                errors++;
                $display("FAIL div5_high1 cyc%0d: got clk/tick/cfg_ready=%b, want %b", i,
                         {clk_out, tick, cfg_ready}, {((i % 5) == 0), ((i % 5) == 0), 1'b1});
            end
        end
    endtask

    task automatic test_clamp_and_duty();
        // div=1 is stored as 2.
        load_idle_and_start(16'd1, 16'd1);
        for (int i = 0; i < 6; i++) begin
            step();
            checks++;
            if ({clk_out, tick} !== {((i % 2) == 0), ((i % 2) == 0)}) begin
                errors++;
                $display("FAIL clamp_div2 cyc%0d: got clk/tick=%b, want %b", i,
                         {clk_out, tick}, {((i % 2) == 0), ((i % 2) == 0)});
            end
        end
        // high >= div keeps clk_out high.
        load_idle_and_start(16'd6, 16'd9);
        for (int i = 0; i < 12; i++) begin
            step();
            checks++;
            if ({clk_out, tick} !== {1'b1, ((i % 6) == 0)}) begin
                errors++;
                $display("FAIL high_ge_div cyc%0d: got clk/tick=%b, want %b", i,
                         {clk_out, tick}, {1'b1, ((i % 6) == 0)});
            end
        end
        // high = 0 keeps clk_out low while tick still pulses.
        load_idle_and_start(16'd6, 16'd0);
        for (int i = 0; i < 12; i++) begin
            step();
            checks++;
            if ({clk_out, tick} !== {1'b0, ((i % 6) == 0)}) begin
                errors++;
                $display("FAIL high_zero cyc%0d: got clk/tick=%b, want %b", i,
                         {clk_out, tick}, {1'b0, ((i % 6) == 0)});
            end
        end
    endtask

    task automatic test_enable_drop();
        load_idle_and_start(16'd8, 16'd4);
        step();
        step();
        checks++;
        if ({clk_out, tick, active} !== 3'b101) begin
            errors++;
            $display("FAIL drop_pre_cnt1: got clk/tick/active=%b, want 101", {clk_out, tick, active});
        end
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({clk_out, tick, active} !== 3'b000) begin
                errors++;
                $display("FAIL drop_idle cyc%0d: got clk/tick/active=%b, want 000", i,
                         {clk_out, tick, active});
            end
        end
        enable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            checks++;
            if ({clk_out, tick, active} !== {((i % 8) < 4), ((i % 8) == 0), 1'b1}) begin
                errors++;
                $display("FAIL restart_div8 cyc%0d: got clk/tick/active=%b, want %b", i,
                         {clk_out, tick, active}, {((i % 8) < 4), ((i % 8) == 0), 1'b1});
            end
        end
    endtask

    task automatic test_reset_mid_period();
        int bad;
        int ticks_seen;
        load_idle_and_start(16'd8, 16'd4);
        repeat (3) step();
        div_val   = 16'd3;
        high_val  = 16'd1;
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
        checks++;
        if ({cfg_ready, active} !== 2'b01) begin
            errors++;
            $display("FAIL pend_before_reset: got cfg_ready/active=%b, want 01", {cfg_ready, active});
        end
        // Assert reset between edges; outputs must clear without a clock edge.
        #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({clk_out, tick, active, cfg_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL async_reset: got clk/tick/active/cfg_ready=%b, want 0001",
                     {clk_out, tick, active, cfg_ready});
        end
        enable = 1'b0;
        @(negedge clk_in);
        reset_n = 1'b1;
        step();
        checks++;
        if ({clk_out, cfg_ready, active} !== 3'b010) begin
            errors++;
            $display("FAIL post_reset_idle: got clk/cfg_ready/active=%b, want 010",
                     {clk_out, cfg_ready, active});
        end
        // Defaults 1024/512 must be in force; the discarded config was 3/1.
        enable     = 1'b1;
        bad        = 0;
        ticks_seen = 0;
        for (int i = 0; i < 1025; i++) begin
            step();
            if (tick === 1'b1) ticks_seen++;
            if ({clk_out, tick} !== {((i % 1024) < 512), ((i % 1024) == 0)}) bad++;
        end
        checks++;
        if (bad != 0 || ticks_seen != 2) begin
            errors++;
            $display("FAIL default_div_after_reset: got %0d bad cycles and %0d ticks, want 0 and 2",
                     bad, ticks_seen);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic_div4();
        test_reload_mid_period();
        test_clamp_and_duty();
        test_enable_drop();
        test_reset_mid_period();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
